// File: rtl/spi_sub_ai.sv
// spi_sub_ai: SPI subordinate, one frame per cs_n -> one memory strobe.
// Define SPI_SUB_AUTOINC_EN to enable the auto-increment pointer ops.
module spi_sub_ai #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              r_en,
  output logic              w_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              err
);
  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

`ifdef SPI_SUB_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, RECV, STROBE, CAPTURE, SEND, DONE
  } state_e;

  function automatic logic op_rd(input logic [1:0] op);
    return (op == 2'b00) || (AUTO && op == 2'b11);
  endfunction

  function automatic logic op_wr(input logic [1:0] op);
    return (op == 2'b01) || (AUTO && op == 2'b10);
  endfunction

  function automatic logic op_bad(input logic [1:0] op);
    return !AUTO && op[1];
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               r_en_q, r_en_d;
  logic               w_en_q, w_en_d;
  logic               err_q, err_d;
  logic               miso_q, miso_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_o_q, data_o_d;
  logic [FRAME_W-1:0] frame;
  logic [1:0]         fop, sop;

`ifdef SPI_SUB_AUTOINC_EN
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
`endif

  // frame as it stands including the bit arriving this edge
  assign frame = {sh_q[FRAME_W-2:0], mosi};
  assign fop   = frame[FRAME_W-1 -: 2];
  assign sop   = sh_q[FRAME_W-1 -: 2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    err_d    = 1'b0;
    addr_d   = addr_q;
    data_o_d = data_o_q;
`ifdef SPI_SUB_AUTOINC_EN
    ptr_d    = ptr_q;
`endif
    if (cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          sh_d    = frame;
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
        RECV: begin
          sh_d  = frame;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = STROBE;
            addr_d  = frame[DATA_W +: ADDR_W];
`ifdef SPI_SUB_AUTOINC_EN
            if (fop[1]) addr_d = ptr_q;
            ptr_d = addr_d + 1'b1;
`endif
            r_en_d = op_rd(fop);
            w_en_d = op_wr(fop);
            err_d  = op_bad(fop);
            if (op_wr(fop)) data_o_d = frame[DATA_W-1:0];
          end
        end
        STROBE: state_d = CAPTURE;
        CAPTURE: begin
          if (op_rd(sop))
            sh_d = {sop, addr_q, data_i};
          else if (op_wr(sop))
            sh_d = {sop, addr_q, sh_q[DATA_W-1:0]};
          else
            sh_d = {sop, addr_q, {DATA_W{1'b0}}};
          cnt_d   = '0;
          state_d = SEND;
        end
        SEND: begin
          sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_o_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      data_o_q <= data_o_d;
    end
  end

`ifdef SPI_SUB_AUTOINC_EN
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign miso_d = (state_q == SEND) & sh_q[FRAME_W-1];

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) miso_q <= 1'b0;
    else        miso_q <= miso_d;
  end

  assign miso   = miso_q;
  assign r_en   = r_en_q;
  assign w_en   = w_en_q;
  assign err    = err_q;
  assign addr   = addr_q;
  assign data_o = data_o_q;

endmodule

// File: tb/tb_spi_sub_ai.sv
// tb_spi_sub_ai: random SPI frames checked against a frame-level model.
// Define SPI_SUB_AUTOINC_EN to exercise the pointer ops at ADDR_W=4.
module tb_spi_sub_ai;
`ifdef SPI_SUB_AUTOINC_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int DW = 32;
  localparam int FW = 2 + AW + DW;
  localparam int DEPTH = 1 << AW;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, r_en, w_en, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_o, data_i;

  int n_chk = 0;
  int n_err = 0;
  int n_r, n_w, n_e, n_multi, s_cyc;
  int cyc = 0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [DW-1:0] dev_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
`ifdef SPI_SUB_AUTOINC_EN
  logic [AW-1:0] ref_ptr = '0;
`endif

  spi_sub_ai #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .r_en(r_en),
    .w_en(w_en), .addr(addr), .data_o(data_o),
    .data_i(data_i), .err(err)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc++;

  // external memory: read data valid one cycle after r_en
  always @(posedge sclk) begin
    if (w_en) dev_mem[addr] <= data_o;
    if (r_en) data_i <= dev_mem[addr];
  end

  always @(negedge sclk) begin
    if (r_en) begin
      n_r++; s_addr = addr; s_cyc = cyc;
    end
    if (w_en) begin
      n_w++; s_addr = addr; s_data = data_o; s_cyc = cyc;
    end
    if (err) begin
      n_e++; s_cyc = cyc;
    end
    if (int'(r_en) + int'(w_en) + int'(err) > 1) n_multi++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] op,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       output logic [FW-1:0] rsp,
                       output int er, output int ew,
                       output int ee,
                       output logic [AW-1:0] ea);
    er = 0; ew = 0; ee = 0; ea = a;
`ifdef SPI_SUB_AUTOINC_EN
    case (op)
      2'b00: begin
        er = 1; rsp = {op, a, ref_mem[a]};
        ref_ptr = a + 1'b1;
      end
      2'b01: begin
        ew = 1; ref_mem[a] = d; rsp = {op, a, d};
        ref_ptr = a + 1'b1;
      end
      2'b10: begin
        ea = ref_ptr; ew = 1; ref_mem[ea] = d;
        rsp = {op, ea, d};
        ref_ptr = ref_ptr + 1'b1;
      end
      default: begin
        ea = ref_ptr; er = 1;
        rsp = {op, ea, ref_mem[ea]};
        ref_ptr = ref_ptr + 1'b1;
      end
    endcase
`else
    case (op)
      2'b00: begin
        er = 1; rsp = {op, a, ref_mem[a]};
      end
      2'b01: begin
        ew = 1; ref_mem[a] = d; rsp = {op, a, d};
      end
      default: begin
        ee = 1; rsp = {op, a, {DW{1'b0}}};
      end
    endcase
`endif
  endtask

  task automatic xfer(input logic [1:0] op,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input int rx_cut, input int tx_cut,
                      output logic [FW-1:0] rsp,
                      output int pf);
    logic [FW-1:0] fr;
    fr = {op, a, d};
    rsp = '0;
    pf = -2;
    n_r = 0; n_w = 0; n_e = 0; n_multi = 0; s_cyc = -1;
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < FW; i++) begin
      if (i == rx_cut) break;
      mosi = fr[FW-1-i];
      @(negedge sclk);
    end
    if (rx_cut >= 0) begin
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (3) @(negedge sclk);
      return;
    end
    pf = cyc;
    mosi = 1'($urandom);
    repeat (2) @(negedge sclk);
    for (int j = 0; j < FW; j++) begin
      if (j == tx_cut) break;
      @(posedge sclk);
      #1;
      rsp[FW-1-j] = miso;
    end
    if (tx_cut >= 0) begin
      @(negedge sclk);
      cs_n = 1'b1;
      @(negedge sclk);
      #1;
      check("miso_after_abort", 64'(miso), 64'd0);
    end else begin
      @(negedge sclk);
      #1;
      check("miso_done", 64'(miso), 64'd0);
      mosi = 1'b1;
      @(negedge sclk);
      cs_n = 1'b1;
    end
    repeat (2) @(negedge sclk);
  endtask

  task automatic run_frame(input logic [1:0] op,
                           input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input int tx_cut);
    logic [FW-1:0] exp_rsp, rsp;
    logic [AW-1:0] ea;
    int er, ew, ee, pf;
    model(op, a, d, exp_rsp, er, ew, ee, ea);
    xfer(op, a, d, -1, tx_cut, rsp, pf);
    check("r_en_pulses", 64'(n_r), 64'(er));
    check("w_en_pulses", 64'(n_w), 64'(ew));
    check("err_pulses", 64'(n_e), 64'(ee));
    check("strobe_overlap", 64'(n_multi), 64'd0);
    check("strobe_cycle", 64'(s_cyc), 64'(pf));
    if (er + ew > 0) check("addr", 64'(s_addr), 64'(ea));
    if (ew > 0) check("data_o", 64'(s_data), 64'(d));
    if (tx_cut < 0)
      check("rsp", 64'(rsp), 64'(exp_rsp));
    else
      check("rsp_partial", 64'(rsp >> (FW - tx_cut)),
            64'(exp_rsp >> (FW - tx_cut)));
  endtask

  task automatic reset_mid_frame();
    logic [FW-1:0] fr;
    fr = {2'b01, AW'($urandom), DW'($urandom)};
    @(negedge sclk);
    cs_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mosi = fr[FW-1-i];
      @(negedge sclk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_outs",
          64'({miso, r_en, w_en, err, addr, data_o}), 64'd0);
`ifdef SPI_SUB_AUTOINC_EN
    ref_ptr = '0;
`endif
    cs_n = 1'b1;
    @(negedge sclk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] rsp;
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int pf, sel;
    for (int k = 0; k < DEPTH; k++) begin
      dev_mem[k] = $urandom;
      ref_mem[k] = dev_mem[k];
    end
    rst_n = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge sclk);
    check("reset_outs",
          64'({miso, r_en, w_en, err, addr, data_o}), 64'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge sclk);

`ifdef SPI_SUB_AUTOINC_EN
    run_frame(2'b01, 4'hE, 32'h5555_0000, -1);
    run_frame(2'b10, 4'h3, 32'h0000_000A, -1);
    run_frame(2'b10, 4'h7, 32'h0000_000B, -1);
    check("wrap_0xF", 64'(dev_mem[15]), 64'h0000_000A);
    check("wrap_0x0", 64'(dev_mem[0]), 64'h0000_000B);
    run_frame(2'b11, 4'h9, 32'h0, -1);
    run_frame(2'b11, 4'h9, 32'h0, -1);
`else
    dev_mem[10'h200] = 32'hDEADBEEF;
    ref_mem[10'h200] = 32'hDEADBEEF;
    run_frame(2'b00, 10'h200, $urandom, -1);
    run_frame(2'b01, 10'h100, 32'hABCDEF12, -1);
    run_frame(2'b00, 10'h100, 32'h0, -1);
    run_frame(2'b10, 10'h050, $urandom, -1);
    run_frame(2'b11, 10'h050, $urandom, -1);
    run_frame(2'b01, 10'h050, 32'h12345678, -1);
    run_frame(2'b00, 10'h050, 32'h0, -1);
`endif

    xfer(2'b01, AW'(5), $urandom, 20, -1, rsp, pf);
    check("rx_abort_strobes", 64'(n_r + n_w + n_e), 64'd0);
    run_frame(2'b00, AW'(5), 32'h0, -1);
    run_frame(2'b01, AW'(6), $urandom, 10);
    run_frame(2'b00, AW'(6), 32'h0, -1);
    reset_mid_frame();
    run_frame(2'b00, AW'(6), 32'h0, -1);

    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom);
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        xfer(op, a, d, $urandom_range(1, FW - 1), -1, rsp, pf);
        check("rnd_rx_abort", 64'(n_r + n_w + n_e), 64'd0);
      end else if (sel == 1) begin
        run_frame(op, a, d, $urandom_range(1, FW - 1));
      end else begin
        run_frame(op, a, d, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_sub_ai.md
# spi_sub_ai

SPI subordinate bridge: a parametrised successor to the fixed 44-bit `spi_sub`. It converts one SPI frame `{op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}` per `cs_n` assertion into a single-cycle memory read or write strobe on the register/memory side, then shifts a response frame back on `miso`. It adds:
- parametrised address and data widths;
- defined, side-effect-free handling of undefined opcodes, with an error pulse;
- an optional auto-increment address pointer.

## Interface
- `ADDR_W`, default 10: address field and `addr` port width.
- `DATA_W`, default 32: data field and data port width.
- Derived, not overridable: `FRAME_W = 2 + ADDR_W + DATA_W` (44 at defaults).

Ports:
- `sclk`  in  1: sole clock. Free-running, including while `cs_n` is high.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_n`  in  1: chip select, active low. Driven by the host on a `sclk` negedge.
- `mosi`  in  1: serial in, MSB first. Host drives it on negedges; the block samples on posedges.
- `miso`  out  1: serial out, MSB first. The block updates it on negedges.
- `r_en`  out  1: memory read strobe, one cycle.
- `w_en`  out  1: memory write strobe, one cycle.
- `addr`  out  ADDR_W: memory address, valid while `r_en` or `w_en` is high.
- `data_o`  out  DATA_W: write data, valid while `w_en` is high.
- `data_i`  in  DATA_W: read data. Must be valid one cycle after `r_en`.
- `err`  out  1: one-cycle pulse when an undefined opcode is received.

## Operation
- **FSM states:** IDLE, RECV, STROBE, CAPTURE, SEND, DONE.
- **IDLE → RECV:** on the first posedge with `cs_n`=0. That posedge captures frame bit `FRAME_W-1`.
- **RECV:** shifts one `mosi` bit per posedge. When bit 0 is captured (posedge P(F), with P1 being the first capture), the FSM moves to STROBE.
- **STROBE:** exactly one cycle, P(F)→P(F+1).
  - op 00: `r_en`=1.
  - op 01: `w_en`=1, `data_o` = frame data field.
  - `addr` = frame address field.
- **CAPTURE:** `data_i` is sampled at posedge P(F+2).
- **Response frame:**
  - read: `{op, addr, data_i}`.
  - write: echo of the received frame.
- **SEND:** response bit `FRAME_W-1-j` is stable on `miso` at posedge P(F+3+j), for j = 0..FRAME_W-1. After the last bit the FSM moves to DONE.
- **DONE:** ignores `mosi` and holds `miso`=0 until `cs_n` is sampled high, then returns to IDLE. One frame per `cs_n` assertion.
- **Undefined opcodes (10, 11):**
  - Behaviour with `SPI_SUB_AUTOINC_EN` defined is given under Configuration.
  - Otherwise: no `r_en`/`w_en`, `err` pulses in the STROBE slot, response is `{op, addr, {DATA_W{1'b0}}}`.
- **`cs_n` high sampled in any state:** return to IDLE next cycle.
  - During RECV: the partial frame is discarded and no strobe is issued.
  - During SEND: shifting stops and `miso` goes to 0. A completed memory access is not undone.
- **Async reset:** `rst_n` low forces IDLE immediately, including mid-frame.
- **Idle levels:** `miso` is 0 whenever not in SEND.

## Timing
- Reset values: `miso`, `r_en`, `w_en`, `err` = 0; `addr`, `data_o` = 0; shift registers = 0; auto-increment pointer = 0.
- `r_en`, `w_en`, `err`, `addr`, `data_o` are registered on posedges. `miso` is registered on negedges.
- Latency: last `mosi` capture (P(F)) → strobe high during P(F)..P(F+1) → response MSB sampled at P(F+3) → response LSB at P(2F+2).
- At defaults, the first response bit is sampled at P47 and the last at P90.
- `r_en`, `w_en` and `err` are mutually exclusive and never high outside the STROBE slot.
- Host contract: `cs_n` high for at least one posedge between frames.

## Configuration
- **`SPI_SUB_AUTOINC_EN` defined:**
  - The block keeps an `ADDR_W`-bit pointer `ptr`.
  - op 00/01: normal access, then `ptr <= addr_field + 1`.
  - op 10 (write-next): write frame data to `ptr`; `addr` = `ptr`.
  - op 11 (read-next): read from `ptr`; `addr` = `ptr`.
  - For ops 10/11: `ptr <= ptr + 1`, the frame address field is ignored, the response address field carries the `ptr` value used, and `err` stays 0.
  - `ptr` wraps modulo 2^ADDR_W. It updates only in the STROBE slot and is unchanged by aborted frames.
- **Not defined:** no pointer logic; ops 10/11 are no-ops that pulse `err`.

## Test plan
- **Read, defaults:** op 00, addr 0x200; memory returns 0xDEADBEEF.
  - `r_en` high for exactly one cycle with `addr`=0x200.
  - Response is `{00, 0x200, 0xDEADBEEF}`; MSB sampled at P47.
- **Write:** op 01, addr 0x100, data 0xABCDEF12.
  - One `w_en` pulse with `data_o`=0xABCDEF12.
  - Response echoes the frame; a following read of 0x100 returns 0xABCDEF12.
- **Undefined opcodes, macro off:** ops 10 and 11 to addr 0x050, then write 0x12345678 to 0x050 and read it back.
  - For ops 10 and 11: no strobes, `err` pulses twice, responses carry zero data.
  - The read-back returns 0x12345678.
- **Auto-increment, macro on, ADDR_W=4:**
  - Write to addr 0xE, then two op 10 frames with data 0xA then 0xB.
  - Writes land at 0xF and 0x0 (wrap).
  - Two op 11 frames then return the contents of 0x1 and 0x2.
- **Aborts:**
  - `cs_n` raised after 20 bits: no strobe; the next full frame decodes correctly.
  - `cs_n` raised mid-SEND: `miso`=0 next negedge; the next frame decodes correctly.
- **Reset:** `rst_n` pulsed low mid-RECV. All outputs return to 0 immediately and the next frame completes normally.
